// File: rtl/cpu19_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu19_pkg
//  Description : Shared types and constants for the 19-bit CPU control path:
//                instruction field widths, sequencer state encoding, opcode
//                constants and the opcode class bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu19_pkg;

  localparam int INSTR_W = 19;
  localparam int OP_W    = 5;
  localparam int SEL_W   = 3;

  // One-hot sequencer states
  typedef enum logic [6:0] {
    IDLE   = 7'b000_0001,
    FETCH  = 7'b000_0010,
    DECODE = 7'b000_0100,
    EXEC   = 7'b000_1000,
    MEM    = 7'b001_0000,
    WB     = 7'b010_0000,
    HALT   = 7'b100_0000
  } state_t;

  // Non-ALU opcodes; ALU functions occupy 0x00-0x0F
  localparam logic [OP_W-1:0] OP_LOAD  = 5'h10;
  localparam logic [OP_W-1:0] OP_STORE = 5'h11;
  localparam logic [OP_W-1:0] OP_JMP   = 5'h12;
  localparam logic [OP_W-1:0] OP_BEQ   = 5'h13;
  localparam logic [OP_W-1:0] OP_NOP   = 5'h14;
  localparam logic [OP_W-1:0] OP_HALT  = 5'h1F;

  // Exactly one flag is set for any opcode
  typedef struct packed {
    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_jmp;
    logic is_beq;
    logic is_nop;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/cpu_op_classify.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_op_classify
//  Description : Combinational opcode classifier. Maps a 5-bit opcode onto a
//                one-hot class bundle; undefined opcodes flag is_illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_op_classify
  import cpu19_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output op_class_t       class_o
);

  // Decode opcode into exactly one class flag
  always_comb begin
    class_o = '0;
    if (opcode_i[OP_W-1] == 1'b0) begin
      class_o.is_alu = 1'b1;
    end else begin
      case (opcode_i)
        OP_LOAD:  class_o.is_load  = 1'b1;
        OP_STORE: class_o.is_store = 1'b1;
        OP_JMP:   class_o.is_jmp   = 1'b1;
        OP_BEQ:   class_o.is_beq   = 1'b1;
        OP_NOP:   class_o.is_nop   = 1'b1;
        OP_HALT:  class_o.is_halt  = 1'b1;
        default:  class_o.is_illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_seq
//  Description : Multi-cycle control sequencer for the 19-bit CPU. Steps each
//                instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
//                PC, IR, ALU, memory and register-file strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_seq
  import cpu19_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [OP_W-1:0]    alu_op,
  output logic [SEL_W-1:0]   rs1_sel,
  output logic [SEL_W-1:0]   rs2_sel,
  output logic [SEL_W-1:0]   rf_wsel,
  output logic               rf_we,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  state_t             state_q;
  logic [INSTR_W-1:0] ir_q;

  // Instruction fields taken from the latched IR
  logic [OP_W-1:0]  ir_op;
  logic [SEL_W-1:0] ir_rd;
  logic [SEL_W-1:0] ir_rs1;
  logic [SEL_W-1:0] ir_rs2;
  logic             unused_imm;

  assign ir_op      = ir_q[18:14];
  assign ir_rd      = ir_q[13:11];
  assign ir_rs1     = ir_q[10:8];
  assign ir_rs2     = ir_q[7:5];
  // Low five bits carry immediate data for the datapath, not for control
  assign unused_imm = ^ir_q[4:0];

  op_class_t cls;

  cpu_op_classify u_classify (
    .opcode_i (ir_op),
    .class_o  (cls)
  );

  // State sequencing and instruction register capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            ir_q    <= instr;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (cls.is_halt)                      state_q <= HALT;
          else if (cls.is_illegal | cls.is_nop) state_q <= FETCH;
          else                                  state_q <= EXEC;
        end
        EXEC: begin
          if (cls.is_alu)                       state_q <= WB;
          else if (cls.is_load | cls.is_store)  state_q <= MEM;
          else                                  state_q <= FETCH;
        end
        MEM: begin
          if (mem_ack) state_q <= cls.is_load ? WB : FETCH;
        end
        WB: begin
          state_q <= FETCH;
        end
        HALT: begin
          if (start) state_q <= FETCH;
        end
        default: begin
          // Corrupted one-hot encoding: return to a known safe state
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobe generation; ack-qualified strobes follow mem_ack within the cycle
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    alu_op  = '0;
    rs1_sel = '0;
    rs2_sel = '0;
    rf_wsel = '0;
    rf_we   = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      DECODE: begin
        busy    = 1'b1;
        rs1_sel = ir_rs1;
        rs2_sel = ir_rs2;
        rf_wsel = ir_rd;
        illegal = cls.is_illegal;
      end
      EXEC: begin
        busy    = 1'b1;
        alu_op  = ir_op;
        rs1_sel = ir_rs1;
        rs2_sel = ir_rs2;
        rf_wsel = ir_rd;
        pc_load = cls.is_jmp | (cls.is_beq & zero_flag);
      end
      MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = cls.is_store;
        rf_wsel = ir_rd;
      end
      WB: begin
        busy    = 1'b1;
        rf_wsel = ir_rd;
        rf_we   = 1'b1;
      end
      HALT: begin
        halted  = 1'b1;
      end
      default: begin
        // IDLE and unreachable encodings keep every strobe low
      end
    endcase
  end

endmodule
`default_nettype wire
